// File: rtl/inst_seq_buffer_pkg.sv
// Shared types and helpers for the multi-context instruction sequencer.
// Sequencer states, output queue depth and a ceil-log2 helper.
package inst_seq_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_e;

   localparam int FIFO_DEPTH = 2;

   // Minimum result of 1 keeps single-context builds with a real select port.
   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/inst_seq_buffer_bram.sv
// Simple dual-port instruction store, read-first, one cycle read latency.
// A same-cycle write to the read address returns the previous contents.
module inst_seq_buffer_bram
   import inst_seq_buffer_pkg::*;
#(
   parameter int WIDTH     = 128,
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/inst_seq_buffer.sv
// Multi-context instruction sequencer: streams a configured program
// from the instruction store with repeat, wrap and abort support.
module inst_seq_buffer
   import inst_seq_buffer_pkg::*;
#(
   parameter int INST_BITS = 128,
   parameter int DEPTH     = 1024,
   parameter int ADDR_BITS = 10,
   parameter int NUM_CTX   = 4,
   parameter int REP_BITS  = 8,
   parameter int CTX_BITS  = clogb2(NUM_CTX)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [INST_BITS-1:0] wr_data,
   input  logic                 cfg_we,
   input  logic [CTX_BITS-1:0]  cfg_ctx,
   input  logic [ADDR_BITS-1:0] cfg_start,
   input  logic [ADDR_BITS-1:0] cfg_end,
   input  logic [REP_BITS-1:0]  cfg_repeat,
   input  logic                 cfg_wrap,
   input  logic                 start,
   input  logic [CTX_BITS-1:0]  start_ctx,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [INST_BITS-1:0] inst_data,
   output logic [ADDR_BITS-1:0] inst_pc,
   output logic                 inst_last
);

   typedef struct packed {
      logic [ADDR_BITS-1:0] first;
      logic [ADDR_BITS-1:0] last;
      logic [REP_BITS-1:0]  rep;
      logic                 wrap;
   } ctx_t;

   function automatic logic [CTX_BITS-1:0] ctx_idx(
      input logic [CTX_BITS-1:0] c
   );
      return CTX_BITS'(int'(c) % NUM_CTX);
   endfunction

   ctx_t                 cfg_q [NUM_CTX];
   ctx_t                 cfg_d [NUM_CTX];
   ctx_t                 run_q, run_d;
   seq_state_e           state_q, state_d;
   logic [ADDR_BITS-1:0] pc_q, pc_d;
   logic                 busy_q, busy_d;

   logic                 rd_vld_q, rd_vld_d;
   logic [ADDR_BITS-1:0] rd_pc_q, rd_pc_d;
   logic                 rd_last_q, rd_last_d;

   logic [INST_BITS-1:0] fdata_q [FIFO_DEPTH];
   logic [INST_BITS-1:0] fdata_d [FIFO_DEPTH];
   logic [ADDR_BITS-1:0] fpc_q [FIFO_DEPTH];
   logic [ADDR_BITS-1:0] fpc_d [FIFO_DEPTH];
   logic                 flast_q [FIFO_DEPTH];
   logic                 flast_d [FIFO_DEPTH];
   logic [1:0]           occ_q, occ_d;
   logic                 rd_ptr_q, rd_ptr_d;

   logic [INST_BITS-1:0] bram_q;
   logic                 head_fifo;
   logic                 pop;
   logic                 fpop;
   logic                 push;
   logic                 wr_idx;
   logic [2:0]           fill;
   logic                 issue;
   logic                 at_end;
   logic [CTX_BITS-1:0]  cfg_sel;
   logic [CTX_BITS-1:0]  start_sel;

   inst_seq_buffer_bram #(
      .WIDTH     (INST_BITS),
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_bram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (issue),
      .raddr (pc_q),
      .rdata (bram_q)
   );

   // Output head is the FIFO when it holds data, else the read in flight.
   assign head_fifo  = (occ_q != 2'd0);
   assign inst_valid = head_fifo || rd_vld_q;
   assign inst_data  = head_fifo ? fdata_q[rd_ptr_q]
                     : (rd_vld_q ? bram_q : '0);
   assign inst_pc    = head_fifo ? fpc_q[rd_ptr_q]
                     : (rd_vld_q ? rd_pc_q : '0);
   assign inst_last  = head_fifo ? flast_q[rd_ptr_q]
                     : (rd_vld_q && rd_last_q);

   assign pop    = inst_valid && inst_ready;
   assign fpop   = pop && head_fifo;
   assign push   = rd_vld_q && !(pop && !head_fifo);
   assign wr_idx = rd_ptr_q ^ occ_q[0];
   assign fill   = {1'b0, occ_q} + {2'b0, rd_vld_q} - {2'b0, pop};
   assign issue  = (state_q == ST_RUN)
                && (fill < 3'(FIFO_DEPTH)) && !abort;
   assign at_end = (pc_q == run_q.last);

   assign cfg_sel   = ctx_idx(cfg_ctx);
   assign start_sel = ctx_idx(start_ctx);

   assign busy = busy_q;
   assign done = pop && inst_last && !abort && reset_n;

   always_comb begin
      cfg_d   = cfg_q;
      fdata_d = fdata_q;
      fpc_d   = fpc_q;
      flast_d = flast_q;
      state_d = state_q;
      run_d   = run_q;
      pc_d    = pc_q;

      if (cfg_we) begin
         cfg_d[cfg_sel] = '{first: cfg_start, last: cfg_end,
                            rep: cfg_repeat, wrap: cfg_wrap};
      end

      rd_vld_d  = issue;
      rd_pc_d   = pc_q;
      rd_last_d = issue && at_end && !run_q.wrap
               && (run_q.rep == '0);

      if (push) begin
         fdata_d[wr_idx] = bram_q;
         fpc_d[wr_idx]   = rd_pc_q;
         flast_d[wr_idx] = rd_last_q;
      end
      occ_d    = occ_q + {1'b0, push} - {1'b0, fpop};
      rd_ptr_d = rd_ptr_q ^ fpop;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               run_d   = cfg_q[start_sel];
               pc_d    = cfg_q[start_sel].first;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               unique case (1'b1)
                  !at_end: pc_d = pc_q + ADDR_BITS'(1);
                  at_end && run_q.wrap: pc_d = run_q.first;
                  at_end && !run_q.wrap && (run_q.rep != '0): begin
                     run_d.rep = run_q.rep - REP_BITS'(1);
                     pc_d      = run_q.first;
                  end
                  at_end && !run_q.wrap && (run_q.rep == '0):
                     state_d = ST_DRAIN;
                  default: state_d = state_q;
               endcase
            end
         end
         ST_DRAIN: begin
            if (pop && inst_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort wins over everything, including a same-cycle start.
      if (abort) begin
         state_d  = ST_IDLE;
         occ_d    = 2'd0;
         rd_ptr_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         run_q     <= '0;
         pc_q      <= '0;
         busy_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_pc_q   <= '0;
         rd_last_q <= 1'b0;
         occ_q     <= 2'd0;
         rd_ptr_q  <= 1'b0;
         for (int i = 0; i < NUM_CTX; i++) begin
            cfg_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         pc_q      <= pc_d;
         busy_q    <= busy_d;
         rd_vld_q  <= rd_vld_d;
         rd_pc_q   <= rd_pc_d;
         rd_last_q <= rd_last_d;
         occ_q     <= occ_d;
         rd_ptr_q  <= rd_ptr_d;
         cfg_q     <= cfg_d;
      end
   end

   always_ff @(posedge clk) begin
      fdata_q <= fdata_d;
      fpc_q   <= fpc_d;
      flast_q <= flast_d;
   end

endmodule

// File: tb/tb_inst_seq_buffer.sv
// Scoreboard bench for inst_seq_buffer: a program-level model pushes
// expected beats, a negedge monitor pops and compares every handshake.
module tb_inst_seq_buffer;

   localparam int IB = 128;
   localparam int DP = 1024;
   localparam int AB = 10;

   typedef struct {
      logic [AB-1:0] pc;
      logic [IB-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en;
   logic [AB-1:0] wr_addr;
   logic [IB-1:0] wr_data;
   logic          cfg_we;
   logic [1:0]    cfg_ctx;
   logic [AB-1:0] cfg_start;
   logic [AB-1:0] cfg_end;
   logic [7:0]    cfg_repeat;
   logic          cfg_wrap;
   logic          start;
   logic [1:0]    start_ctx;
   logic          abort;
   logic          busy;
   logic          done;
   logic          inst_valid;
   logic          inst_ready;
   logic [IB-1:0] inst_data;
   logic [AB-1:0] inst_pc;
   logic          inst_last;

   inst_seq_buffer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cfg_we     (cfg_we),
      .cfg_ctx    (cfg_ctx),
      .cfg_start  (cfg_start),
      .cfg_end    (cfg_end),
      .cfg_repeat (cfg_repeat),
      .cfg_wrap   (cfg_wrap),
      .start      (start),
      .start_ctx  (start_ctx),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc),
      .inst_last  (inst_last)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            beats = 0;
   int            done_cnt = 0;
   logic [IB-1:0] tb_mem [DP];
   beat_t         exp_q [$];
   bit            rand_ready = 1'b0;

   task automatic chk(input string name, input logic [IB-1:0] act,
                      input logic [IB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Program model: rep+1 passes of first..last, stepping mod DEPTH.
   task automatic push_program(input int first, input int last,
                               input int rep);
      for (int p = 0; p <= rep; p++) begin
         int pc;
         pc = first;
         forever begin
            exp_q.push_back('{pc: AB'(pc), data: tb_mem[pc], last: 1'b0});
            if (pc == last) break;
            pc = (pc + 1) % DP;
         end
      end
      exp_q[exp_q.size()-1].last = 1'b1;
   endtask

   task automatic cfg(input int ctx, input int s, input int e,
                      input int rep, input bit wrap);
      cfg_we     = 1'b1;
      cfg_ctx    = 2'(ctx);
      cfg_start  = AB'(s);
      cfg_end    = AB'(e);
      cfg_repeat = 8'(rep);
      cfg_wrap   = wrap;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic launch(input int ctx);
      start     = 1'b1;
      start_ctx = 2'(ctx);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_timeout"}, IB'(n < budget), IB'(1));
      chk({name, "_left"}, IB'(exp_q.size()), IB'(0));
   endtask

   initial begin
      inst_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         inst_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   bit            hold_v = 1'b0;
   bit            busy_chk = 1'b0;
   logic [AB-1:0] hold_pc;
   logic [IB-1:0] hold_data;
   logic          hold_last;

   always @(negedge clk) begin
      if (reset_n && !abort) begin
         if (hold_v) begin
            chk("stall_valid", IB'(inst_valid), IB'(1));
            chk("stall_pc", IB'(inst_pc), IB'(hold_pc));
            chk("stall_data", inst_data, hold_data);
            chk("stall_last", IB'(inst_last), IB'(hold_last));
         end
         hold_v = 1'b0;
         if (busy_chk) chk("busy_after_done", IB'(busy), IB'(0));
         busy_chk = 1'b0;
         if (inst_valid && inst_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got pc %0d expected none",
                        inst_pc);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_pc", IB'(inst_pc), IB'(e.pc));
               chk("beat_data", inst_data, e.data);
               chk("beat_last", IB'(inst_last), IB'(e.last));
            end
         end else if (inst_valid) begin
            hold_v    = 1'b1;
            hold_pc   = inst_pc;
            hold_data = inst_data;
            hold_last = inst_last;
         end
         if (done) begin
            chk("done_on_last", IB'(inst_valid && inst_ready && inst_last),
                IB'(1));
            done_cnt++;
            busy_chk = 1'b1;
         end
      end else begin
         hold_v   = 1'b0;
         busy_chk = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int b0;
      int n;
      reset_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cfg_we = 1'b0; cfg_ctx = '0; cfg_start = '0; cfg_end = '0;
      cfg_repeat = '0; cfg_wrap = 1'b0;
      start = 1'b0; start_ctx = '0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", IB'(busy), IB'(0));
      chk("rst_done", IB'(done), IB'(0));
      chk("rst_valid", IB'(inst_valid), IB'(0));
      chk("rst_data", inst_data, IB'(0));
      chk("rst_pc", IB'(inst_pc), IB'(0));
      chk("rst_last", IB'(inst_last), IB'(0));
      reset_n = 1'b1;

      for (int a = 0; a < DP; a++) begin
         tb_mem[a] = {$urandom, $urandom, $urandom, $urandom};
         wr_en = 1'b1; wr_addr = AB'(a); wr_data = tb_mem[a];
         @(posedge clk); #1;
      end
      wr_en = 1'b0;

      // T1: simple run with latency checks
      cfg(0, 4, 7, 0, 1'b0);
      push_program(4, 7, 0);
      d0 = done_cnt;
      launch(0);
      chk("t1_busy_next", IB'(busy), IB'(1));
      chk("t1_valid_early", IB'(inst_valid), IB'(0));
      @(posedge clk); #1;
      chk("t1_valid_2cyc", IB'(inst_valid), IB'(1));
      wait_idle("t1", 100);
      chk("t1_done_cnt", IB'(done_cnt - d0), IB'(1));

      // T2: repeat loop
      cfg(1, 10, 11, 2, 1'b0);
      push_program(10, 11, 2);
      d0 = done_cnt;
      launch(1);
      wait_idle("t2", 100);
      chk("t2_done_cnt", IB'(done_cnt - d0), IB'(1));

      // T3: address wrap and single-instruction program
      cfg(2, 1022, 1, 0, 1'b0);
      push_program(1022, 1, 0);
      launch(2);
      wait_idle("t3a", 100);
      cfg(0, 5, 5, 0, 1'b0);
      push_program(5, 5, 0);
      d0 = done_cnt;
      launch(0);
      wait_idle("t3b", 100);
      chk("t3b_done_cnt", IB'(done_cnt - d0), IB'(1));

      // T4: random backpressure on the repeat program
      rand_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_program(10, 11, 2);
         d0 = done_cnt;
         launch(1);
         wait_idle("t4", 400);
         chk("t4_done_cnt", IB'(done_cnt - d0), IB'(1));
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;

      // T5: infinite wrap, abort after 7 beats, then restart
      cfg(3, 0, 2, 0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back('{pc: AB'(k % 3), data: tb_mem[k % 3],
                           last: 1'b0});
      end
      d0 = done_cnt;
      b0 = beats;
      launch(3);
      n = 0;
      while (beats - b0 < 7 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_reach7", IB'(n < 100), IB'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t5_valid_drop", IB'(inst_valid), IB'(0));
      chk("t5_busy_drop", IB'(busy), IB'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("t5_valid_stay", IB'(inst_valid), IB'(0));
      chk("t5_beats", IB'(beats - b0), IB'(7));
      chk("t5_no_done", IB'(done_cnt - d0), IB'(0));
      exp_q.delete();
      cfg(0, 4, 7, 0, 1'b0);
      push_program(4, 7, 0);
      launch(0);
      wait_idle("t5_restart", 100);

      // T6a: start while busy ignored, cfg write to running ctx
      push_program(10, 11, 2);
      d0 = done_cnt;
      launch(1);
      @(posedge clk); #1;
      launch(0);
      cfg(1, 30, 40, 0, 1'b0);
      wait_idle("t6a", 100);
      chk("t6a_done_cnt", IB'(done_cnt - d0), IB'(1));

      // T6b: abort and start in the same cycle
      start = 1'b1; start_ctx = 2'd0; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("t6b_busy", IB'(busy), IB'(0));
      @(posedge clk); #1;
      chk("t6b_valid", IB'(inst_valid), IB'(0));
      chk("t6b_busy2", IB'(busy), IB'(0));

      // T6c: reset in the middle of a run
      push_program(30, 40, 0);
      d0 = done_cnt;
      launch(1);
      repeat (4) @(posedge clk);
      #1;
      chk("t6c_busy_pre", IB'(busy), IB'(1));
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("t6c_busy", IB'(busy), IB'(0));
      chk("t6c_valid", IB'(inst_valid), IB'(0));
      chk("t6c_last", IB'(inst_last), IB'(0));
      reset_n = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("t6c_valid_stay", IB'(inst_valid), IB'(0));
      chk("t6c_no_done", IB'(done_cnt - d0), IB'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
